// File: rtl/wb_interconnect_1xn.sv
// Wishbone B4 pipelined 1-master to N-slave interconnect.
// Address decode, outstanding tracking, default slave and response timeout.
module wb_interconnect_1xn #(
  parameter int NUM_SLAVES = 6,
  parameter logic [32*NUM_SLAVES-1:0] ADR_BEGIN = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] ADR_END = {NUM_SLAVES{32'h0}},
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    m_cyc_i,
  input  logic                    m_stb_i,
  input  logic                    m_we_i,
  input  logic [31:0]             m_adr_i,
  input  logic [31:0]             m_dat_i,
  input  logic [3:0]              m_sel_i,
  output logic                    m_stall_o,
  output logic                    m_ack_o,
  output logic                    m_err_o,
  output logic [31:0]             m_dat_o,
  output logic [NUM_SLAVES-1:0]   s_cyc_o,
  output logic [NUM_SLAVES-1:0]   s_stb_o,
  output logic                    s_we_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  output logic [3:0]              s_sel_o,
  input  logic [NUM_SLAVES-1:0]   s_stall_i,
  input  logic [NUM_SLAVES-1:0]   s_ack_i,
  input  logic [NUM_SLAVES-1:0]   s_err_i,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  output logic                    timeout_o,
  output logic [31:0]             err_adr_o
);

  localparam int SW = $clog2(NUM_SLAVES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] DEF = SW'(NUM_SLAVES);
  localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
  localparam bit TEN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   eadr_q, eadr_d;
  logic          def_q, def_d;
  logic          tmo_q, tmo_d;

  logic [SW-1:0] dec;
  logic          stall_dec;
  logic          ack_cur;
  logic          err_cur;
  logic [31:0]   dat_cur;
  logic          req;
  logic          blocked;
  logic          acc;
  logic          resp;
  logic          busy;
  logic          to_hit;

  assign s_we_o  = m_we_i;
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;

  assign timeout_o = tmo_q;
  assign err_adr_o = eadr_q;

  // Address decode: scan downwards so the lowest matching index wins.
  always_comb begin
    dec = DEF;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (m_adr_i >= ADR_BEGIN[32*k +: 32] &&
          m_adr_i <= ADR_END[32*k +: 32])
        dec = SW'(k);
    end
  end

  // Select stall of the decoded slave and responses of the current slave.
  always_comb begin
    stall_dec = 1'b0;
    ack_cur   = 1'b0;
    err_cur   = 1'b0;
    dat_cur   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (dec == SW'(k))
        stall_dec = s_stall_i[k];
      if (sel_q == SW'(k)) begin
        ack_cur = s_ack_i[k];
        err_cur = s_err_i[k];
        dat_cur = s_dat_i[32*k +: 32];
      end
    end
  end

  assign req = m_cyc_i & m_stb_i & ~wb_rst_i;
  assign busy = (state_q == BUSY);

  assign blocked = (state_q == ABORT) | (cnt_q == MAXO)
                 | ((cnt_q != 4'd0) & (dec != sel_q));

  assign m_stall_o = req & (blocked | ((dec != DEF) & stall_dec));
  assign acc = req & ~m_stall_o;

  assign m_ack_o = busy & (sel_q != DEF) & ack_cur;
  assign m_err_o = (busy & ((sel_q == DEF) ? def_q : err_cur))
                 | ((state_q == ABORT) & (cnt_q != 4'd0));
  assign m_dat_o = m_ack_o ? dat_cur : 32'h0;
  assign resp = m_ack_o | m_err_o;

  assign to_hit = TEN & busy & ~acc & ~resp & (timer_q == TLIM);

  // Per-slave strobe and cycle; cycle drops while aborting.
  always_comb begin
    s_stb_o = '0;
    s_cyc_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      s_stb_o[k] = req & ~blocked & (dec == SW'(k));
      s_cyc_o[k] = m_cyc_i & ~wb_rst_i & (state_q != ABORT)
                 & (s_stb_o[k]
                    | ((cnt_q != 4'd0) & (sel_q == SW'(k))));
    end
  end

  // Next state: outstanding count, timer, abort drain and error address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = acc ? dec : sel_q;
    timer_d = timer_q;
    adr_d   = acc ? m_adr_i : adr_q;
    eadr_d  = eadr_q;
    def_d   = acc & (dec == DEF);
    tmo_d   = 1'b0;
    if (acc && dec == DEF)
      eadr_d = m_adr_i;
    if (!m_cyc_i) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      timer_d = '0;
      def_d   = 1'b0;
    end else if (state_q == ABORT) begin
      cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
      timer_d = '0;
      if (cnt_q <= 4'd1)
        state_d = IDLE;
    end else if (to_hit) begin
      state_d = ABORT;
      tmo_d   = 1'b1;
      eadr_d  = adr_q;
      timer_d = '0;
    end else begin
      case ({acc, resp})
        2'b10:   cnt_d = cnt_q + 4'd1;
        2'b01:   cnt_d = cnt_q - 4'd1;
        default: cnt_d = cnt_q;
      endcase
      state_d = (cnt_d != 4'd0) ? BUSY : IDLE;
      if (acc || resp || state_q == IDLE)
        timer_d = '0;
      else
        timer_d = timer_q + TW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= '0;
      timer_q <= '0;
      adr_q   <= 32'h0;
      eadr_q  <= 32'h0;
      def_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      adr_q   <= adr_d;
      eadr_q  <= eadr_d;
      def_q   <= def_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// Directed bench for wb_interconnect_1xn.
// Decode table plus sequences for pipelining, switch, abort and reset.
module tb_wb_interconnect_1xn;

  localparam int N = 6;
  localparam logic [32*N-1:0] AB = {
    32'h4000_0000, 32'h5000_0000, 32'h3000_0000,
    32'h1000_8000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [32*N-1:0] AE = {
    32'h4000_FFFF, 32'h4FFF_FFFF, 32'h3000_FFFF,
    32'h1000_800F, 32'h0000_FFFF, 32'h0FFF_FFFF};

  logic          clk = 1'b0;
  logic          rst;
  logic          m_cyc, m_stb, m_we;
  logic [31:0]   m_adr, m_dat;
  logic [3:0]    m_sel;
  logic          m_stall, m_ack, m_err;
  logic [31:0]   m_dat_o;
  logic [N-1:0]  s_cyc, s_stb;
  logic          s_we;
  logic [31:0]   s_adr, s_dat_o;
  logic [3:0]    s_sel;
  logic [N-1:0]  s_stall, s_ack, s_err;
  logic [32*N-1:0] s_dat;
  logic          timeout;
  logic [31:0]   err_adr;

  int nvec = 0;
  int nfail = 0;

  wb_interconnect_1xn #(
    .NUM_SLAVES(N), .ADR_BEGIN(AB), .ADR_END(AE),
    .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_stall_o(m_stall), .m_ack_o(m_ack), .m_err_o(m_err),
    .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_stall_i(s_stall), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_dat_i(s_dat),
    .timeout_o(timeout), .err_adr_o(err_adr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [5:0]  stall;
    logic [5:0]  stb;
    logic        mstall;
    logic        err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    int n;
    vt[0]  = '{32'h0000_0010, 6'h00, 6'b000001, 1'b0, 1'b0};
    vt[1]  = '{32'h0FFF_FFFF, 6'h00, 6'b000001, 1'b0, 1'b0};
    vt[2]  = '{32'h1000_0000, 6'h00, 6'b000000, 1'b0, 1'b1};
    vt[3]  = '{32'h1000_7FFF, 6'h00, 6'b000000, 1'b0, 1'b1};
    vt[4]  = '{32'h1000_8000, 6'h00, 6'b000100, 1'b0, 1'b0};
    vt[5]  = '{32'h1000_800F, 6'h00, 6'b000100, 1'b0, 1'b0};
    vt[6]  = '{32'h1000_8010, 6'h00, 6'b000000, 1'b0, 1'b1};
    vt[7]  = '{32'h3000_0004, 6'h08, 6'b001000, 1'b1, 1'b0};
    vt[8]  = '{32'h5000_0000, 6'h00, 6'b000000, 1'b0, 1'b1};
    vt[9]  = '{32'h4000_FFFF, 6'h00, 6'b100000, 1'b0, 1'b0};
    vt[10] = '{32'h2000_0000, 6'h3F, 6'b000000, 1'b0, 1'b1};

    rst = 1'b1;
    m_cyc = 0; m_stb = 0; m_we = 0;
    m_adr = 0; m_dat = 32'h1234_5678; m_sel = 4'hF;
    s_stall = 0; s_ack = 0; s_err = 0;
    for (int k = 0; k < N; k++)
      s_dat[32*k +: 32] = 32'hA000_0000 + k;
    #1;
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_cyc", s_cyc, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_eadr", err_adr, 0);
    nxt(); nxt();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      nxt();
      m_cyc = 1; m_stb = 1; m_adr = vt[i].adr; s_stall = vt[i].stall;
      #1;
      chk($sformatf("v%0d_stb", i), s_stb, vt[i].stb);
      chk($sformatf("v%0d_cyc", i), s_cyc, vt[i].stb);
      chk($sformatf("v%0d_stall", i), m_stall, vt[i].mstall);
      nxt();
      m_stb = 0; s_stall = 0;
      #1;
      chk($sformatf("v%0d_err", i), m_err, vt[i].err);
      if (vt[i].err)
        chk($sformatf("v%0d_eadr", i), err_adr, vt[i].adr);
      nxt();
      m_cyc = 0;
      #1;
      chk($sformatf("v%0d_cycdrop", i), s_cyc, 0);
      nxt();
    end

    // single read from slave 2
    nxt();
    m_cyc = 1; m_stb = 1; m_adr = 32'h1000_8004;
    #1 chk("rd_stb", s_stb, 6'b000100);
    nxt();
    m_stb = 0; s_ack = 6'b000001;
    #1;
    chk("rd_foreign", m_ack, 0);
    chk("rd_stb0", s_stb, 0);
    chk("rd_cyc", s_cyc, 6'b000100);
    nxt();
    s_ack = 6'b000100; s_dat[64 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack", m_ack, 1);
    chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    nxt();
    s_ack = 0;
    #1;
    chk("rd_idle_cyc", s_cyc, 0);
    chk("rd_idle_dat", m_dat_o, 0);
    m_cyc = 0;

    // three pipelined reads to slave 0
    nxt();
    m_cyc = 1; m_stb = 1; m_adr = 32'h100;
    #1 chk("pl_s1", m_stall, 0);
    nxt();
    m_adr = 32'h104;
    #1 chk("pl_s2", m_stall, 0);
    nxt();
    m_adr = 32'h108;
    #1 chk("pl_s3", m_stall, 1);
    nxt();
    s_ack = 6'b000001; s_dat[0 +: 32] = 32'h11;
    #1;
    chk("pl_s3b", m_stall, 1);
    chk("pl_a1", m_ack, 1);
    chk("pl_d1", m_dat_o, 32'h11);
    nxt();
    s_dat[0 +: 32] = 32'h22;
    #1;
    chk("pl_s3c", m_stall, 0);
    chk("pl_d2", m_dat_o, 32'h22);
    nxt();
    m_stb = 0; s_dat[0 +: 32] = 32'h33;
    #1 chk("pl_d3", m_dat_o, 32'h33);
    nxt();
    s_ack = 0;
    #1 chk("pl_cyc", s_cyc, 0);
    m_cyc = 0;

    // write slave 0, then read slave 3
    nxt();
    m_cyc = 1; m_stb = 1; m_we = 1; m_adr = 32'h10;
    #1;
    chk("sw_we", s_we, 1);
    chk("sw_s1", m_stall, 0);
    nxt();
    m_we = 0; m_adr = 32'h3000_0000;
    #1;
    chk("sw_s2", m_stall, 1);
    chk("sw_stb2", s_stb, 0);
    nxt();
    s_ack = 6'b000001;
    #1;
    chk("sw_s3", m_stall, 1);
    chk("sw_a0", m_ack, 1);
    nxt();
    s_ack = 0;
    #1;
    chk("sw_stb3", s_stb, 6'b001000);
    chk("sw_s4", m_stall, 0);
    nxt();
    m_stb = 0; s_ack = 6'b001000; s_dat[96 +: 32] = 32'hCAFE_0003;
    #1 chk("sw_d3", m_dat_o, 32'hCAFE_0003);
    nxt();
    s_ack = 0; m_cyc = 0;

    // back-to-back unmapped requests
    nxt();
    m_cyc = 1; m_stb = 1; m_adr = 32'h2000_0000;
    #1 chk("df_s1", m_stall, 0);
    nxt();
    m_adr = 32'h2000_0004;
    #1;
    chk("df_s2", m_stall, 0);
    chk("df_e1", m_err, 1);
    chk("df_a1", err_adr, 32'h2000_0000);
    nxt();
    m_stb = 0;
    #1;
    chk("df_e2", m_err, 1);
    chk("df_a2", err_adr, 32'h2000_0004);
    nxt();
    #1 chk("df_e3", m_err, 0);
    m_cyc = 0;

    // hung slave 5
    nxt();
    m_cyc = 1; m_stb = 1; m_adr = 32'h4000_0000;
    #1 chk("to_s1", m_stall, 0);
    nxt();
    m_adr = 32'h4000_0004;
    #1 chk("to_s2", m_stall, 0);
    nxt();
    m_stb = 0;
    #1 chk("to_cyc", s_cyc, 6'b100000);
    n = 0;
    while (!timeout && n < 40) begin
      nxt();
      #1 n++;
    end
    chk("to_wait", n, 9);
    chk("to_cycdrop", s_cyc, 0);
    chk("to_err1", m_err, 1);
    s_ack = 6'b100000;
    #1 chk("to_late1", m_ack, 0);
    nxt();
    #1;
    chk("to_pulse", timeout, 0);
    chk("to_err2", m_err, 1);
    chk("to_eadr", err_adr, 32'h4000_0004);
    chk("to_late2", m_ack, 0);
    nxt();
    #1;
    chk("to_err3", m_err, 0);
    chk("to_late3", m_ack, 0);
    s_ack = 0; m_cyc = 0;

    // async reset with two outstanding
    nxt();
    m_cyc = 1; m_stb = 1; m_adr = 32'h200;
    nxt();
    m_adr = 32'h204;
    nxt();
    m_stb = 0; s_ack = 6'b000001;
    #1 chk("ar_ack", m_ack, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_ack0", m_ack, 0);
    chk("ar_err0", m_err, 0);
    chk("ar_cyc0", s_cyc, 0);
    #1 rst = 1'b0;
    s_ack = 0;
    nxt();
    m_stb = 1; m_adr = 32'h1000_8000;
    #1;
    chk("ar_s", m_stall, 0);
    chk("ar_stb", s_stb, 6'b000100);
    nxt();
    m_stb = 0;
    #1 chk("ar_cyc", s_cyc, 6'b000100);
    s_ack = 6'b000100; s_dat[64 +: 32] = 32'h0BAD_F00D;
    #1 chk("ar_dat", m_dat_o, 32'h0BAD_F00D);
    nxt();
    s_ack = 0; m_cyc = 0;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
